// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants and state encoding for the data RAM arbiter.
// Bus widths and the memory size follow the SOPC's RegBus and data-memory definitions.
package data_ram_arbiter_pkg;

  localparam int REG_BUS_W       = 32;
  localparam int DATA_ADDR_BUS_W = 32;
  localparam int DATA_MEM_NUM    = 131072;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT0  = 3'd1,
    GNT1  = 3'd2,
    DONE0 = 3'd3,
    DONE1 = 3'd4
  } arb_state_t;

endpackage

// File: rtl/data_ram_arbiter_rr_pick2.sv
// Two-request round-robin selector: on a tie the master that was not granted last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic any
);

  assign any   = req0 | req1;
  assign grant = req1 & (~req0 | ~last);

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single data RAM port between the CPU (master 0) and a secondary master (master 1).
// Each access is a one-cycle grant followed by a one-cycle registered acknowledge.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DATA_ADDR_BUS_W,
  parameter int DATA_W    = REG_BUS_W,
  parameter int RAM_WORDS = DATA_MEM_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              stall_req_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  // Handshake: a master raises req with we/addr/sel/wdata and holds all of them
  // stable until it sees its one-cycle ack; ack (with err) completes the access.

  arb_state_t state, next_state;
  logic       last_grant;
  logic       pick_grant, pick_any;
  logic       oor0, oor1;
  logic       in_grant, grant_m1, grant_oor;

  rr_pick2 u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (last_grant),
    .grant (pick_grant),
    .any   (pick_any)
  );

  assign oor0 = {2'b00, m0_addr[ADDR_W-1:2]} >= ADDR_W'(RAM_WORDS);
  assign oor1 = {2'b00, m1_addr[ADDR_W-1:2]} >= ADDR_W'(RAM_WORDS);

  assign in_grant  = (state == GNT0) || (state == GNT1);
  assign grant_m1  = (state == GNT1);
  assign grant_oor = grant_m1 ? oor1 : oor0;

  assign stall_req_o = m0_req & ~m0_ack;

  // The owning master's own req is stale in its DONE cycle, so only the other side is looked at.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick_any) next_state = pick_grant ? GNT1 : GNT0;
      end
      GNT0:    next_state = DONE0;
      GNT1:    next_state = DONE1;
      DONE0:   next_state = m1_req ? GNT1 : IDLE;
      DONE1:   next_state = m0_req ? GNT0 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (in_grant && !grant_oor) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = grant_m1 ? m1_we    : m0_we;
      ram_addr_o = grant_m1 ? m1_addr  : m0_addr;
      ram_sel_o  = grant_m1 ? m1_sel   : m0_sel;
      ram_data_o = grant_m1 ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state  <= next_state;
      m0_ack <= (state == GNT0);
      m1_ack <= (state == GNT1);
      m0_err <= (state == GNT0) && oor0;
      m1_err <= (state == GNT1) && oor1;
      if (state == GNT0) begin
        last_grant <= 1'b0;
        m0_rdata   <= (!oor0 && !m0_we) ? ram_data_i : '0;
      end
      if (state == GNT1) begin
        last_grant <= 1'b1;
        m1_rdata   <= (!oor1 && !m1_we) ? ram_data_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a small behavioural RAM behind the shared port.
module tb_data_ram_arbiter;

  localparam int RAM_WORDS = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        stall_req_o, ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

  logic [31:0] mem [0:1023];
  int          n_checks = 0;
  int          n_errors = 0;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_WORDS(RAM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .stall_req_o(stall_req_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural RAM: combinational read, byte-lane write at the rising edge
  assign ram_data_i = mem[ram_addr_o[11:2]];
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_sel = sel; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_sel = sel; m1_wdata = wdata;
    end
  endtask

  // one full access from IDLE; returns in IDLE with req dropped
  task automatic run_access(input int m, input logic we, input logic [31:0] addr,
                            input logic [3:0] sel, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int cyc);
    logic got;
    set_m(m, 1'b1, we, addr, sel, wdata);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 8) begin
      tick();
      cyc++;
      got = (m == 0) ? m0_ack : m1_ack;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    rdata = (m == 0) ? m0_rdata : m1_rdata;
    err   = (m == 0) ? m0_err : m1_err;
    set_m(m, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    logic        seen;

    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    tick();
    check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    check("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("rst_ce", {31'd0, ram_ce_o}, 32'd0);
    rst = 1'b0;

    // reset asserted in the middle of GNT1
    set_m(1, 1'b1, 1'b0, 32'h24, 4'hF, 32'd0);
    tick();
    check("gnt1_ce", {31'd0, ram_ce_o}, 32'd1);
    check("gnt1_addr", ram_addr_o, 32'h24);
    rst = 1'b1;
    #1;
    check("midrst_ce", {31'd0, ram_ce_o}, 32'd0);
    check("midrst_addr", ram_addr_o, 32'd0);
    check("midrst_sel", {28'd0, ram_sel_o}, 32'd0);
    check("midrst_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("midrst_m1_err", {31'd0, m1_err}, 32'd0);
    check("midrst_m1_rdata", m1_rdata, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | m1_ack | ram_ce_o;
    end
    check("no_ack_after_rst", {31'd0, seen}, 32'd0);

    // simultaneous request after reset: m0 first, then m1
    set_m(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h11111111);
    set_m(1, 1'b1, 1'b1, 32'h24, 4'hF, 32'h22222222);
    tick();
    check("cont_gnt0_ce", {31'd0, ram_ce_o}, 32'd1);
    check("cont_gnt0_addr", ram_addr_o, 32'h20);
    tick();
    check("cont_done0_m0_ack", {31'd0, m0_ack}, 32'd1);
    check("cont_done0_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("cont_done0_ce", {31'd0, ram_ce_o}, 32'd0);
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    check("cont_gnt1_addr", ram_addr_o, 32'h24);
    check("cont_gnt1_data", ram_data_o, 32'h22222222);
    check("cont_gnt1_m0_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    check("cont_done1_m1_ack", {31'd0, m1_ack}, 32'd1);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    check("cont_mem20", mem[8], 32'h11111111);
    check("cont_mem24", mem[9], 32'h22222222);

    // both held continuously: acks alternate m0, m1 every 2 cycles
    set_m(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0);
    set_m(1, 1'b1, 1'b0, 32'h24, 4'hF, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("alt_m0_ack_c%0d", i), {31'd0, m0_ack}, (i == 2 || i == 6) ? 32'd1 : 32'd0);
      check($sformatf("alt_m1_ack_c%0d", i), {31'd0, m1_ack}, (i == 4 || i == 8) ? 32'd1 : 32'd0);
    end
    check("alt_m0_rdata", m0_rdata, 32'h11111111);
    check("alt_m1_rdata", m1_rdata, 32'h22222222);
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();

    // single write cycle by cycle
    set_m(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    check("wr_stall_idle", {31'd0, stall_req_o}, 32'd1);
    tick();
    check("wr_gnt_ce", {31'd0, ram_ce_o}, 32'd1);
    check("wr_gnt_we", {31'd0, ram_we_o}, 32'd1);
    check("wr_gnt_addr", ram_addr_o, 32'h10);
    check("wr_gnt_sel", {28'd0, ram_sel_o}, 32'hF);
    check("wr_gnt_data", ram_data_o, 32'hDEADBEEF);
    check("wr_gnt_stall", {31'd0, stall_req_o}, 32'd1);
    tick();
    check("wr_done_ack", {31'd0, m0_ack}, 32'd1);
    check("wr_done_err", {31'd0, m0_err}, 32'd0);
    check("wr_done_ce", {31'd0, ram_ce_o}, 32'd0);
    check("wr_done_stall", {31'd0, stall_req_o}, 32'd0);
    check("wr_mem", mem[4], 32'hDEADBEEF);
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    check("wr_idle_ack", {31'd0, m0_ack}, 32'd0);

    // read-back and byte-lane write
    run_access(0, 1'b0, 32'h10, 4'hF, 32'd0, rd, er, cyc);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", {31'd0, er}, 32'd0);
    check("rd_latency", cyc, 32'd2);
    check("rd_hold", m0_rdata, 32'hDEADBEEF);
    run_access(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, rd, er, cyc);
    check("bwr_rdata_zero", rd, 32'd0);
    check("bwr_mem", mem[4], 32'hDEADBEAA);
    run_access(0, 1'b0, 32'h10, 4'hF, 32'd0, rd, er, cyc);
    check("bwr_readback", rd, 32'hDEADBEAA);

    // out-of-range read by m1
    set_m(1, 1'b1, 1'b0, RAM_WORDS * 4, 4'hF, 32'd0);
    tick();
    check("oor_gnt_ce", {31'd0, ram_ce_o}, 32'd0);
    check("oor_gnt_we", {31'd0, ram_we_o}, 32'd0);
    check("oor_gnt_addr", ram_addr_o, 32'd0);
    tick();
    check("oor_ack", {31'd0, m1_ack}, 32'd1);
    check("oor_err", {31'd0, m1_err}, 32'd1);
    check("oor_rdata", m1_rdata, 32'd0);
    set_m(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();
    check("oor_err_clear", {31'd0, m1_err}, 32'd0);

    // last in-range word, then an out-of-range write that must not land
    run_access(1, 1'b1, (RAM_WORDS - 1) * 4, 4'hF, 32'h5A5A5A5A, rd, er, cyc);
    check("top_wr_err", {31'd0, er}, 32'd0);
    check("top_wr_mem", mem[1023], 32'h5A5A5A5A);
    run_access(1, 1'b1, RAM_WORDS * 4, 4'hF, 32'hBADBAD00, rd, er, cyc);
    check("oor_wr_err", {31'd0, er}, 32'd1);
    check("oor_wr_mem0", mem[0], 32'd0);
    check("oor_wr_mem_top", mem[1023], 32'h5A5A5A5A);
    run_access(1, 1'b0, (RAM_WORDS - 1) * 4, 4'hF, 32'd0, rd, er, cyc);
    check("top_rd", rd, 32'h5A5A5A5A);

    // stale request: m0 keeps req high through DONE0
    set_m(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
    tick();
    check("stale_gnt_ce", {31'd0, ram_ce_o}, 32'd1);
    tick();
    check("stale_done_ack", {31'd0, m0_ack}, 32'd1);
    tick();
    check("stale_idle_ce", {31'd0, ram_ce_o}, 32'd0);
    check("stale_idle_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    check("stale_regnt_ce", {31'd0, ram_ce_o}, 32'd1);
    tick();
    check("stale_reack", {31'd0, m0_ack}, 32'd1);
    set_m(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
